tri_divisor_search: RTL and testbench
=====================================

# tri_divisor_search

Parametrised search engine for the first triangular number T(n) = n(n+1)/2 whose divisor count strictly exceeds a threshold. The threshold is supplied at run time. The block adds a start/done handshake, synchronous reset, overflow detection and reporting of n and the divisor count. It uses the coprime split T(n) = g(n)·g(n+1), where g(m) = m/2 for even m and m otherwise, so d(T(n)) = d(g(n))·d(g(n+1)). Only one new divisor count is computed per step. It sits beside the other Euler solver blocks as a reusable core; top-level problem wrappers tie `req` to a constant.

## Interface
- N_W, 32: width of n and of the divisor-counter operand
- CNT_W, 16: width of a single divisor count
- REQ_W, 16: width of the threshold input
- LIMIT, 1<<20: largest n+1 allowed; exceeding it is an error
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE, DONE or ERR
- req  in  REQ_W  threshold; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  level; high while result is valid, cleared by next accepted start
- error  out  1  level; n+1 exceeded LIMIT, cleared by next accepted start
- result  out  2·N_W  T(n) of the hit
- n_out  out  N_W  n of the hit
- divisors  out  2·CNT_W  d(T(n)) of the hit

## Operation
- States: IDLE, PREP, CALC, CHECK, DONE, ERR.
- IDLE/DONE/ERR + start=1:
  - latch req;
  - n←1, prev←1 (d(g(1))=1);
  - clear done/error;
  - go to PREP.
- PREP:
  - if n+1 > LIMIT → ERR;
  - else pulse sub-module start with operand g(n+1) → CALC.
- CALC: wait for sub-module done; cur←count → CHECK.
- CHECK: prod = prev·cur, computed at 2·CNT_W, no truncation.
  - If prod > req (unsigned): result ← n(n+1)/2 at 2·N_W width, n_out←n, divisors←prod → DONE.
  - Else: prev←cur, n←n+1 → PREP.
- DONE/ERR hold all outputs until an accepted start or rst.
- start in PREP/CALC/CHECK is ignored; req changes after latching are ignored.
- req=0: the first check at n=1 gives prod=1 > 0, so the search finishes at n=1.
- rst at any time:
  - state←IDLE;
  - all outputs 0;
  - internal n/prev/cur and sub-module return to reset.
  - No partial result survives.

## Timing
- Reset values: busy=0, done=0, error=0, result=0, n_out=0, divisors=0.
- Accepted start at edge k: busy=1 from k+1.
- Sub-module latency for operand v: done pulses exactly floor(sqrt(v))+2 cycles after its start is sampled. Operand 0 gives done after 2 cycles with count 0.
- Each search step costs 1 (PREP) + sub-module latency + 1 (CHECK) cycles.
- done/error rise in the cycle busy falls; both are registered outputs.
- start and rst in the same cycle: rst wins.

## Structure
- Shared package `euler_pkg`: state encoding constants; default N_W/CNT_W/LIMIT.
- One sub-module, `divisor_count_seq`:
  - ports: clk, rst, start, value[N_W], busy, done (1-cycle pulse), count[CNT_W];
  - trial division with i from 1 while i·i ≤ value;
  - add 2 per divisor, or 1 when i·i = value.
- Divide and modulo stay inside `divisor_count_seq`. The top level uses only shifts, add, multiply and compare.

## Test plan
- req=5, start pulse → done=1, n_out=7, result=28, divisors=6, error=0.
- req=500 → n_out=12375, result=76576500, divisors=576.
- req=0 → n_out=1, result=1, divisors=1; req=1 → n_out=2, result=3, divisors=2.
- LIMIT=100, req=500 → error=1, done=0, busy falls in the cycle PREP sees n+1=101.
- Mid-search checks:
  - start pulses while busy are ignored;
  - rst pulse mid-CALC forces all outputs to 0 next cycle;
  - a fresh start with req=5 then yields 28.
- Standalone `divisor_count_seq`:
  - value=36 → count=9, done 8 cycles after start;
  - value=1 → count=1, done 3 cycles after start;
  - value=0 → count=0.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared definitions for the Euler solver cores.
// Holds the default widths and search limit, plus the state encodings of
// the triangular-divisor search FSM and of the sequential divisor counter.
package euler_pkg;

  localparam int unsigned DEF_N_W   = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_REQ_W = 16;
  localparam int unsigned DEF_LIMIT = 1 << 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } search_state_t;

  typedef enum logic {
    DC_IDLE = 1'b0,
    DC_RUN  = 1'b1
  } dc_state_t;

endpackage

// File: rtl/divisor_count_seq.sv
// Sequential divisor counter using trial division.
// For i = 1, 2, ... while i*i <= value, every i dividing value contributes
// the pair (i, value/i): +2, or +1 when i is the exact square root.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         accepted only while idle; latches value
//   value [N_W]   operand
//   busy          high while the trial loop runs
//   done          one-cycle pulse, count valid from then on
//   count [CNT_W] number of divisors of the latched value (0 for value 0)
// done is sampled high floor(sqrt(value))+2 rising edges after start was
// sampled: one edge per trial i = 1..floor(sqrt), one failing edge that
// raises done, and the edge that samples it.
module divisor_count_seq
  import euler_pkg::*;
#(
  parameter int unsigned N_W   = DEF_N_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   value,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  dc_state_t        state_reg, state_next;
  logic [N_W-1:0]   value_reg, value_next;
  logic [N_W-1:0]   i_reg, i_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             done_reg, done_next;

  logic [2*N_W-1:0] i_sq;
  logic             in_range;
  logic             is_root;
  logic             divides;

  assign i_sq     = (2*N_W)'(i_reg) * (2*N_W)'(i_reg);
  assign in_range = i_sq <= (2*N_W)'(value_reg);
  assign is_root  = i_sq == (2*N_W)'(value_reg);
  // i_reg never drops below 1 (reset and start both load 1), so the
  // modulo never sees a zero divisor.
  assign divides  = (value_reg % i_reg) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DC_IDLE;
      value_reg <= '0;
      i_reg     <= N_W'(1);
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      i_reg     <= i_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    i_next     = i_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    case (state_reg)
      DC_IDLE: begin
        if (start) begin
          value_next = value;
          i_next     = N_W'(1);
          count_next = '0;
          state_next = DC_RUN;
        end
      end
      DC_RUN: begin
        if (in_range) begin
          if (divides)
            count_next = count_reg + (is_root ? CNT_W'(1) : CNT_W'(2));
          i_next = i_reg + N_W'(1);
        end else begin
          done_next  = 1'b1;
          state_next = DC_IDLE;
        end
      end
      default: state_next = DC_IDLE;
    endcase
  end

  assign busy  = (state_reg == DC_RUN);
  assign done  = done_reg;
  assign count = count_reg;

endmodule

// File: rtl/tri_divisor_search.sv
// Search for the first triangular number T(n) = n(n+1)/2 whose divisor
// count strictly exceeds the run-time threshold req.
// T(n) = g(n)*g(n+1) with g(m) = m/2 (m even) or m (m odd); the two factors
// are coprime, so d(T(n)) = d(g(n))*d(g(n+1)). Each step counts only the
// new factor g(n+1) and reuses d(g(n)) from the previous step.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           accepted in IDLE/DONE/ERR; latches req
//   req [REQ_W]     divisor-count threshold
//   busy            search in progress
//   done            level, result/n_out/divisors valid
//   error           level, n+1 exceeded LIMIT before a hit
//   result [2*N_W]  T(n) of the hit
//   n_out [N_W]     n of the hit
//   divisors [2*CNT_W] d(T(n)) of the hit
module tri_divisor_search
  import euler_pkg::*;
#(
  parameter int unsigned N_W   = DEF_N_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned REQ_W = DEF_REQ_W,
  parameter int unsigned LIMIT = DEF_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [REQ_W-1:0]   req,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2*N_W-1:0]   result,
  output logic [N_W-1:0]     n_out,
  output logic [2*CNT_W-1:0] divisors
);

  localparam int unsigned    CMP_W   = (2*CNT_W > REQ_W) ? 2*CNT_W : REQ_W;
  localparam logic [N_W:0]   LIMIT_W = (N_W+1)'(LIMIT);

  search_state_t      state_reg, state_next;
  logic [REQ_W-1:0]   req_reg, req_next;
  logic [N_W-1:0]     n_reg, n_next;
  logic [N_W-1:0]     g_prev_reg, g_prev_next;   // g(n)
  logic [CNT_W-1:0]   prev_reg, prev_next;       // d(g(n))
  logic [CNT_W-1:0]   cur_reg, cur_next;         // d(g(n+1))
  logic [2*N_W-1:0]   result_reg, result_next;
  logic [N_W-1:0]     n_out_reg, n_out_next;
  logic [2*CNT_W-1:0] divisors_reg, divisors_next;

  logic [N_W:0]       n_plus1;
  logic [N_W-1:0]     g_cur;
  logic [2*CNT_W-1:0] prod;
  logic [2*N_W-1:0]   tri_val;
  logic               hit;

  logic               sub_start;
  logic               sub_busy;
  logic               sub_done;
  logic [CNT_W-1:0]   sub_count;

  assign n_plus1 = {1'b0, n_reg} + (N_W+1)'(1);
  assign g_cur   = n_plus1[0] ? n_plus1[N_W-1:0] : n_plus1[N_W:1];
  assign prod    = (2*CNT_W)'(prev_reg) * (2*CNT_W)'(cur_reg);
  // g(n)*g(n+1) equals n(n+1)/2 without needing a halving step.
  assign tri_val = (2*N_W)'(g_prev_reg) * (2*N_W)'(g_cur);
  assign hit     = CMP_W'(prod) > CMP_W'(req_reg);

  divisor_count_seq #(
    .N_W   (N_W),
    .CNT_W (CNT_W)
  ) u_count (
    .clk   (clk),
    .rst   (rst),
    .start (sub_start),
    .value (g_cur),
    .busy  (sub_busy),
    .done  (sub_done),
    .count (sub_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      req_reg      <= '0;
      n_reg        <= '0;
      g_prev_reg   <= '0;
      prev_reg     <= '0;
      cur_reg      <= '0;
      result_reg   <= '0;
      n_out_reg    <= '0;
      divisors_reg <= '0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      n_reg        <= n_next;
      g_prev_reg   <= g_prev_next;
      prev_reg     <= prev_next;
      cur_reg      <= cur_next;
      result_reg   <= result_next;
      n_out_reg    <= n_out_next;
      divisors_reg <= divisors_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    n_next        = n_reg;
    g_prev_next   = g_prev_reg;
    prev_next     = prev_reg;
    cur_next      = cur_reg;
    result_next   = result_reg;
    n_out_next    = n_out_reg;
    divisors_next = divisors_reg;
    sub_start     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          req_next    = req;
          n_next      = N_W'(1);
          g_prev_next = N_W'(1);     // g(1) = 1
          prev_next   = CNT_W'(1);   // d(g(1)) = 1
          state_next  = ST_PREP;
        end
      end
      ST_PREP: begin
        if (n_plus1 > LIMIT_W) begin
          state_next = ST_ERR;
        end else if (!sub_busy) begin
          // The counter is always idle here because CALC waits for its
          // done; the guard just keeps a start from ever being dropped.
          sub_start  = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (sub_done) begin
          cur_next   = sub_count;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hit) begin
          result_next   = tri_val;
          n_out_next    = n_reg;
          divisors_next = prod;
          state_next    = ST_DONE;
        end else begin
          prev_next   = cur_reg;
          g_prev_next = g_cur;
          n_next      = n_plus1[N_W-1:0];
          state_next  = ST_PREP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg == ST_PREP) || (state_reg == ST_CALC) ||
                    (state_reg == ST_CHECK);
  assign done     = (state_reg == ST_DONE);
  assign error    = (state_reg == ST_ERR);
  assign result   = result_reg;
  assign n_out    = n_out_reg;
  assign divisors = divisors_reg;

endmodule

// File: tb/tb_tri_divisor_search.sv
module tb_tri_divisor_search;
  import euler_pkg::*;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // default-parameter search engine
  logic        start;
  logic [15:0] req;
  logic        busy, done, error;
  logic [63:0] result;
  logic [31:0] n_out, divisors;
  // LIMIT=100 search engine
  logic        lstart;
  logic [15:0] lreq;
  logic        lbusy, ldone, lerror;
  logic [63:0] lresult;
  logic [31:0] ln_out, ldivisors;
  // standalone divisor counter
  logic        dc_start;
  logic [31:0] dc_value;
  logic        dc_busy, dc_done;
  logic [15:0] dc_count;

  tri_divisor_search dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .busy(busy), .done(done),
    .error(error), .result(result), .n_out(n_out), .divisors(divisors)
  );

  tri_divisor_search #(.LIMIT(100)) dut_lim (
    .clk(clk), .rst(rst), .start(lstart), .req(lreq), .busy(lbusy), .done(ldone),
    .error(lerror), .result(lresult), .n_out(ln_out), .divisors(ldivisors)
  );

  divisor_count_seq dc (
    .clk(clk), .rst(rst), .start(dc_start), .value(dc_value),
    .busy(dc_busy), .done(dc_done), .count(dc_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Reference: brute-force divisor count of T(n) itself, n = 1, 2, ...
  function automatic longint unsigned ndiv(input longint unsigned t);
    longint unsigned c = 0;
    for (longint unsigned i = 1; i * i <= t; i++)
      if (t % i == 0) c += (i * i == t) ? 1 : 2;
    return c;
  endfunction

  function automatic void ref_search(input int unsigned r, input int unsigned limit,
                                     output longint unsigned n, output longint unsigned t,
                                     output longint unsigned d, output bit err);
    err = 1'b0; t = 0; d = 0;
    for (n = 1; n < 1000000; n++) begin
      if (n + 1 > limit) begin err = 1'b1; return; end
      t = n * (n + 1) / 2;
      d = ndiv(t);
      if (d > r) return;
    end
    err = 1'b1;
  endfunction

  // Start a search on the default engine, wait for done/error, return cycles
  // counted from the edge that accepted start. With disturb set, a start with
  // req=0 is pulsed mid-search and req is left changed.
  task automatic search(input int unsigned r, input bit disturb, output int cyc);
    req   = r[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared_by_start", done, 0);
    cyc = 0;
    while (!done && !error && cyc < BUDGET) begin
      if (disturb && cyc == 10) begin start = 1'b1; req = 16'd0; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= BUDGET) begin
      checks++; errors++;
      $display("FAIL search_timeout: still busy after %0d cycles, expected done", cyc);
    end
    chk("busy_falls_with_done", busy, 0);
  endtask

  typedef struct {
    int unsigned     req;
    int unsigned     n;
    longint unsigned t;
    int unsigned     d;
  } vec_t;

  typedef struct {
    int unsigned value;
    int unsigned count;
    int unsigned lat;
  } dc_vec_t;

  vec_t    vecs[8];
  dc_vec_t dvecs[6];

  initial begin
    int              cyc, lat;
    int unsigned     r;
    longint unsigned en, et, ed;
    bit              eerr;

    vecs[0] = '{0, 1, 1, 1};
    vecs[1] = '{1, 2, 3, 2};
    vecs[2] = '{2, 3, 6, 4};
    vecs[3] = '{3, 3, 6, 4};
    vecs[4] = '{4, 7, 28, 6};
    vecs[5] = '{5, 7, 28, 6};
    vecs[6] = '{6, 8, 36, 9};
    vecs[7] = '{9, 15, 120, 16};

    dvecs[0] = '{36, 9, 8};
    dvecs[1] = '{1, 1, 3};
    dvecs[2] = '{0, 0, 2};
    dvecs[3] = '{12, 6, 5};
    dvecs[4] = '{97, 2, 11};
    dvecs[5] = '{100, 9, 12};

    rst = 1'b1; start = 1'b0; req = '0; lstart = 1'b0; lreq = '0;
    dc_start = 1'b0; dc_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_result", result, 0);
    chk("reset_n_out", n_out, 0);
    chk("reset_divisors", divisors, 0);
    rst = 1'b0;

    // Table of small thresholds with hand-derived answers.
    foreach (vecs[k]) begin
      search(vecs[k].req, 1'b0, cyc);
      chk($sformatf("vec%0d_done", k), done, 1);
      chk($sformatf("vec%0d_error", k), error, 0);
      chk($sformatf("vec%0d_n_out", k), n_out, vecs[k].n);
      chk($sformatf("vec%0d_result", k), result, vecs[k].t);
      chk($sformatf("vec%0d_divisors", k), divisors, vecs[k].d);
      // Step cost is 1 + (floor(sqrt(g))+2) + 1 per n.
      if (vecs[k].req == 0) chk("req0_cycles", cyc, 5);
      if (vecs[k].req == 5) chk("req5_cycles", cyc, 38);
    end

    // Outputs hold in DONE.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", done, 1);
    chk("hold_result", result, 120);

    // Start pulse and req change while busy are ignored.
    search(5, 1'b1, cyc);
    chk("disturb_n_out", n_out, 7);
    chk("disturb_result", result, 28);
    chk("disturb_cycles", cyc, 38);

    // Randomized thresholds against the brute-force model.
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 40);
      ref_search(r, DEF_LIMIT, en, et, ed, eerr);
      search(r, 1'b0, cyc);
      chk($sformatf("rnd%0d_req%0d_error", k, r), error, longint'(eerr));
      chk($sformatf("rnd%0d_req%0d_n_out", k, r), n_out, en);
      chk($sformatf("rnd%0d_req%0d_result", k, r), result, et);
      chk($sformatf("rnd%0d_req%0d_divisors", k, r), divisors, ed);
    end

    // rst and start in the same cycle: rst wins.
    rst = 1'b1; start = 1'b1; req = 16'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_result", result, 0);
    @(posedge clk); #1;
    chk("rst_start_idle", busy, 0);

    // Give the engine a non-zero result, then reset mid-CALC.
    search(9, 1'b0, cyc);
    req = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_result", result, 0);
    chk("midrst_n_out", n_out, 0);
    chk("midrst_divisors", divisors, 0);
    search(5, 1'b0, cyc);
    chk("after_rst_result", result, 28);
    chk("after_rst_cycles", cyc, 38);

    // LIMIT=100 engine: req=500 runs out of n.
    ref_search(500, 100, en, et, ed, eerr);
    lreq = 16'd500; lstart = 1'b1;
    @(posedge clk); #1;
    lstart = 1'b0;
    chk("lim_busy_after_start", lbusy, 1);
    cyc = 0;
    while (!ldone && !lerror && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      checks++; errors++;
      $display("FAIL lim_timeout: still busy after %0d cycles, expected error", cyc);
    end
    chk("lim_error", lerror, longint'(eerr));
    chk("lim_done", ldone, 0);
    chk("lim_busy_falls", lbusy, 0);
    chk("lim_result_untouched", lresult, 0);
    lreq = 16'd5; lstart = 1'b1;
    @(posedge clk); #1;
    lstart = 1'b0;
    chk("lim_error_cleared", lerror, 0);
    cyc = 0;
    while (!ldone && !lerror && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("lim_req5_done", ldone, 1);
    chk("lim_req5_n_out", ln_out, 7);
    chk("lim_req5_result", lresult, 28);
    chk("lim_req5_divisors", ldivisors, 6);

    // Standalone divisor counter: count and latency in edges from the start
    // edge up to the edge that samples done.
    foreach (dvecs[k]) begin
      dc_value = dvecs[k].value; dc_start = 1'b1;
      @(posedge clk); #1;
      dc_start = 1'b0;
      chk($sformatf("dc%0d_busy", dvecs[k].value), dc_busy, 1);
      lat = 1;
      while (!dc_done && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("dc%0d_latency", dvecs[k].value), lat, dvecs[k].lat);
      chk($sformatf("dc%0d_count", dvecs[k].value), dc_count, dvecs[k].count);
      @(posedge clk); #1;
      chk($sformatf("dc%0d_done_pulse", dvecs[k].value), dc_done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
